// File: rtl/range_pkg.sv
// range_pkg: shared burst FSM states and default sample width
package range_pkg;
    typedef enum logic [1:0] {IDLE, GO, STREAM, CAPTURE} state_t;
    localparam int RANGE_WIDTH = 16;
endpackage

// File: rtl/range_burst_driver_if.sv
// range_burst_driver_if: producer and range finder signals of the burst driver
interface range_burst_driver_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     start;
    logic                     busy;
    logic [WIDTH-1:0]         data_out;
    logic                     go;
    logic                     finish;
    logic [WIDTH-1:0]         range_in;
    logic [WIDTH-1:0]         result;
    logic                     done;
    modport master (
        input  wr_en, wr_data, start, range_in,
        output full, count, overflow, busy, data_out, go, finish, result, done
    );
    modport slave (
        output wr_en, wr_data, start, range_in,
        input  full, count, overflow, busy, data_out, go, finish, result, done
    );
endinterface

// File: rtl/range_sample_fifo.sv
// range_sample_fifo: circular sample buffer with sticky overflow on writes while full
module range_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;
    assign full     = count_q == (AW+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign head     = mem_q[rd_ptr_q];
    // a push while full is dropped even when a pop happens in the same cycle
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        mem_d      = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        overflow_d = overflow_q || (push && full);
    end
    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) mem_q <= mem_d;
    // pointer, occupancy and overflow registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: rtl/range_burst_driver.sv
// range_burst_driver: plays a buffered burst to the range finder and captures its range
module range_burst_driver
    import range_pkg::*;
#(
    parameter int WIDTH = RANGE_WIDTH,
    parameter int DEPTH = 8
) (
    input logic                 clock,
    input logic                 reset,
    range_burst_driver_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t           state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d, result_q, result_d;
    logic             go_q, go_d, finish_q, finish_d, done_q, done_d;
    logic             pop, empty;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    range_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (head),
        .full      (bus.full),
        .empty     (empty),
        .count     (count),
        .overflow  (bus.overflow)
    );
    assign bus.count    = count;
    assign bus.busy     = state_q != IDLE;
    assign bus.data_out = data_q;
    assign bus.go       = go_q;
    assign bus.finish   = finish_q;
    assign bus.result   = result_q;
    assign bus.done     = done_q;
    // rem_q counts samples still to emit after the one on data_out; a single
    // sample burst re-drives s0 with finish so go and finish never coincide
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        data_d   = data_q;
        result_d = result_q;
        go_d     = 1'b0;
        finish_d = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !empty) begin
                state_d = GO;
                go_d    = 1'b1;
                data_d  = head;
                pop     = 1'b1;
                rem_d   = count - CW'(1);
            end
            GO, STREAM: if (finish_q) begin
                state_d = CAPTURE;
            end else begin
                state_d  = STREAM;
                finish_d = rem_q <= CW'(1);
                if (rem_q != '0) begin
                    pop    = 1'b1;
                    data_d = head;
                    rem_d  = rem_q - CW'(1);
                end
            end
            CAPTURE: begin
                state_d  = IDLE;
                result_d = bus.range_in;
                done_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // FSM and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            result_q <= result_d;
            go_q     <= go_d;
            finish_q <= finish_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_range_burst_driver.sv
// tb_range_burst_driver: randomized and directed bursts against a queue model
module tb_range_burst_driver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errors = 0;
    logic [15:0] model[$];
    bit ovf = 1'b0;
    logic [15:0] rf_lo, rf_hi;
    logic rf_act;

    range_burst_driver_if #(.WIDTH(16), .DEPTH(8)) bus ();
    range_burst_driver #(.WIDTH(16), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // behavioural range finder: max minus min of the samples framed by go..finish
    always @(posedge clock) begin
        if (reset) begin
            rf_act <= 1'b0;
            rf_lo  <= '0;
            rf_hi  <= '0;
        end else if (bus.go) begin
            rf_lo  <= bus.data_out;
            rf_hi  <= bus.data_out;
            rf_act <= 1'b1;
        end else if (rf_act) begin
            if (bus.data_out < rf_lo) rf_lo <= bus.data_out;
            if (bus.data_out > rf_hi) rf_hi <= bus.data_out;
            if (bus.finish) rf_act <= 1'b0;
        end
    end
    assign bus.range_in = rf_hi - rf_lo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        @(negedge clock);
        bus.wr_en = 1'b1;
        bus.wr_data = v;
        @(negedge clock);
        bus.wr_en = 1'b0;
        if (model.size() < 8) model.push_back(v);
        else ovf = 1'b1;
        chk("count", 32'(bus.count), 32'(model.size()));
        chk("full", 32'(bus.full), 32'(model.size() == 8));
        chk("overflow", 32'(bus.overflow), 32'(ovf));
    endtask

    // t counts negedges after the edge accepting start; l is the number of data cycles
    task automatic burst(input bit poke);
        logic [15:0] s[$];
        logic [15:0] lo, hi;
        int n, l, k;
        n = model.size();
        lo = 16'hFFFF;
        hi = 16'h0000;
        for (int i = 0; i < n; i++) begin
            s.push_back(model[i]);
            if (model[i] < lo) lo = model[i];
            if (model[i] > hi) hi = model[i];
        end
        model.delete();
        l = (n == 1) ? 2 : n;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int t = 0; t <= l + 1; t++) begin
            k = (t < n) ? t : n - 1;
            chk("go", 32'(bus.go), 32'(t == 0));
            chk("finish", 32'(bus.finish), 32'(t == l - 1));
            chk("busy", 32'(bus.busy), 32'(t <= l));
            chk("done", 32'(bus.done), 32'(t == l + 1));
            if (t < l) chk("data_out", 32'(bus.data_out), 32'(s[k]));
            if (t == l + 1) chk("result", 32'(bus.result), 32'(hi - lo));
            if (poke && t == 0) begin
                bus.wr_en = 1'b1;
                bus.wr_data = 16'hABCD;
            end
            if (poke && t == 1) begin
                bus.wr_en = 1'b0;
                bus.start = 1'b1;
                model.push_back(16'hABCD);
            end
            if (poke && t == 2) bus.start = 1'b0;
            if (t < l + 1) @(negedge clock);
        end
        chk("count_after", 32'(bus.count), 32'(model.size()));
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_go", 32'(bus.go), 0);
        chk("rst_finish", 32'(bus.finish), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        reset = 1'b0;

        push(16'h7FFF); push(16'h8000); push(16'h8001); push(16'h7FFE); push(16'h7FFF);
        burst(1'b0);
        chk("tp1_result", 32'(bus.result), 32'h0003);

        push(16'h0100); push(16'h0000); push(16'hFFFF); push(16'h0200);
        burst(1'b0);
        chk("tp2_result", 32'(bus.result), 32'hFFFF);

        push(16'h1234);
        burst(1'b0);
        chk("tp3_result", 32'(bus.result), 32'h0000);

        for (int v = 1; v <= 9; v++) push(16'(v));
        burst(1'b0);
        chk("ovf_empty", 32'(bus.count), 0);

        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("empty_go", 32'(bus.go), 0);
            chk("empty_busy", 32'(bus.busy), 0);
            chk("empty_done", 32'(bus.done), 0);
            @(negedge clock);
        end

        push(16'h0A00); push(16'h0B00); push(16'h0C00);
        burst(1'b1);
        burst(1'b0);

        for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model.delete();
        ovf = 1'b0;
        chk("mid_go", 32'(bus.go), 0);
        chk("mid_finish", 32'(bus.finish), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_count", 32'(bus.count), 0);
        chk("mid_overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_done", 32'(bus.done), 0);
            @(negedge clock);
        end
        push(16'h0005); push(16'h0009);
        burst(1'b0);
        chk("mid_result", 32'(bus.result), 32'h0004);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) push(16'($urandom));
            burst(1'($urandom_range(0, 1)));
        end
        if (model.size() > 0) burst(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
